// File: rtl/dc_decode_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : dc_decode_queue_if
// Brief    : Fetch-side and dispatch-side signal bundle for dc_decode_queue.
// Revision : 1.0
// ============================================================================
interface dc_decode_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              IF_valid;
  logic [31:0]       DC_in_pc;
  logic [31:0]       DC_in_inst;
  logic              DC_in_jump;
  logic              DC_ready;
  logic              rob_ready;
  logic              IS_ready;
  logic              ld_ready;
  logic              st_ready;
  logic              stall;
  logic              mispredict;
  logic              out_valid;
  logic              dispatch_fire;
  logic [31:0]       out_pc;
  logic [31:0]       out_inst;
  logic [31:0]       out_imm;
  logic [4:0]        out_op;
  logic [2:0]        out_f3;
  logic [6:0]        out_f7;
  logic [5:0]        out_A_rs1;
  logic [5:0]        out_A_rs2;
  logic [5:0]        out_A_rd;
  logic              out_allocate_rd;
  logic [2:0]        out_fu_sel;
  logic              out_jump;
  logic [CNT_W-1:0]  count;

  modport slave (
    input  IF_valid, DC_in_pc, DC_in_inst, DC_in_jump,
    input  rob_ready, IS_ready, ld_ready, st_ready, stall, mispredict,
    output DC_ready, out_valid, dispatch_fire,
    output out_pc, out_inst, out_imm, out_op, out_f3, out_f7,
    output out_A_rs1, out_A_rs2, out_A_rd, out_allocate_rd, out_fu_sel, out_jump,
    output count
  );

  modport master (
    output IF_valid, DC_in_pc, DC_in_inst, DC_in_jump,
    output rob_ready, IS_ready, ld_ready, st_ready, stall, mispredict,
    input  DC_ready, out_valid, dispatch_fire,
    input  out_pc, out_inst, out_imm, out_op, out_f3, out_f7,
    input  out_A_rs1, out_A_rs2, out_A_rd, out_allocate_rd, out_fu_sel, out_jump,
    input  count
  );
endinterface
`default_nettype wire

// File: rtl/dc_decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : dc_decode_queue
// Brief    : Decode-at-enqueue in-order FIFO between fetch and dispatch, with
//            optional empty-queue bypass and mispredict flush.
// Revision : 1.0
// ============================================================================
module dc_decode_queue #(
  parameter int DEPTH     = 4,
  parameter bit BYPASS_EN = 1'b1,
  parameter int ROB_IDX_W = 5
) (
  input wire clk,
  input wire rst,
  dc_decode_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_fload  = 7'b0000111;
  localparam logic [6:0] c_op_imm    = 7'b0010011;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_fstore = 7'b0100111;
  localparam logic [6:0] c_op_r      = 7'b0110011;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_fp     = 7'b1010011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_csr    = 7'b1110011;

  localparam logic [2:0] c_fu_alu   = 3'd0;
  localparam logic [2:0] c_fu_mul   = 3'd1;
  localparam logic [2:0] c_fu_div   = 3'd2;
  localparam logic [2:0] c_fu_falu  = 3'd3;
  localparam logic [2:0] c_fu_load  = 3'd6;
  localparam logic [2:0] c_fu_store = 3'd7;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] imm;
    logic [5:0]  a_rs1;
    logic [5:0]  a_rs2;
    logic [5:0]  a_rd;
    logic        allocate_rd;
    logic [2:0]  fu_sel;
    logic        jump;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;

  entry_t             live;
  entry_t             sel;
  logic [31:0]        inst;
  logic [6:0]         op;
  logic               is_fp;
  logic               has_entries;
  logic               dc_ready;
  logic               enq;
  logic               need_ok;
  logic               out_valid;
  logic               fire;
  logic               wr;
  logic               deq;
  logic               unused_rob_idx_w;

  assign unused_rob_idx_w = (ROB_IDX_W > 0);

  // Live decode of the fetched instruction; captured into the FIFO on write.
  always_comb begin
    inst  = bus.DC_in_inst;
    op    = inst[6:0];
    is_fp = (op == c_op_fp);
    live  = '0;

    live.pc    = bus.DC_in_pc;
    live.inst  = inst;
    live.jump  = bus.DC_in_jump;
    live.a_rs1 = {is_fp, inst[19:15]};
    live.a_rs2 = {is_fp || (op == c_op_fstore), inst[24:20]};
    live.a_rd  = {is_fp || (op == c_op_fload), inst[11:7]};

    case (op)
      c_op_branch: live.imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      c_op_jal:    live.imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      c_op_imm, c_op_load, c_op_fload, c_op_jalr:
                   live.imm = {{20{inst[31]}}, inst[31:20]};
      c_op_store, c_op_fstore:
                   live.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      c_op_lui, c_op_auipc:
                   live.imm = {inst[31:12], 12'b0};
      c_op_csr:    live.imm = {20'b0, inst[31:20]};
      default:     live.imm = '0;
    endcase

    case (op)
      c_op_r:                  live.fu_sel = (inst[31:25] == 7'b0000001) ?
                                             (inst[14] ? c_fu_div : c_fu_mul) : c_fu_alu;
      c_op_fp:                 live.fu_sel = c_fu_falu;
      c_op_load, c_op_fload:   live.fu_sel = c_fu_load;
      c_op_store, c_op_fstore: live.fu_sel = c_fu_store;
      default:                 live.fu_sel = c_fu_alu;
    endcase

    live.allocate_rd = !((op == c_op_store) || (op == c_op_fstore) || (op == c_op_branch))
                       && (live.a_rd != 6'd0);
  end

  // Handshake: the head entry takes priority over the live decode.
  always_comb begin
    has_entries = (count_q != '0);
    sel         = has_entries ? mem_q[head_q] : live;
    dc_ready    = (count_q < CNT_W'(DEPTH)) && !bus.mispredict;
    enq         = bus.IF_valid && dc_ready;
    need_ok     = bus.rob_ready && bus.IS_ready
                  && ((sel.fu_sel != c_fu_load)  || bus.ld_ready)
                  && ((sel.fu_sel != c_fu_store) || bus.st_ready);
    out_valid   = has_entries || (BYPASS_EN && bus.IF_valid && !bus.mispredict);
    fire        = out_valid && need_ok && !bus.stall && !bus.mispredict;
    wr          = enq && !(fire && !has_entries);
    deq         = fire && has_entries;
  end

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.mispredict) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wr) begin
        mem_d[tail_q] = live;
        tail_d        = tail_q + PTR_W'(1);
      end
      if (deq) begin
        head_d = head_q + PTR_W'(1);
      end
      case ({wr, deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= mem_d[k];
      end
    end
  end

  assign bus.DC_ready        = dc_ready;
  assign bus.out_valid       = out_valid;
  assign bus.dispatch_fire   = fire;
  assign bus.out_pc          = sel.pc;
  assign bus.out_inst        = sel.inst;
  assign bus.out_imm         = sel.imm;
  assign bus.out_op          = sel.inst[6:2];
  assign bus.out_f3          = sel.inst[14:12];
  assign bus.out_f7          = sel.inst[31:25];
  assign bus.out_A_rs1       = sel.a_rs1;
  assign bus.out_A_rs2       = sel.a_rs2;
  assign bus.out_A_rd        = sel.a_rd;
  assign bus.out_allocate_rd = sel.allocate_rd;
  assign bus.out_fu_sel      = sel.fu_sel;
  assign bus.out_jump        = sel.jump;
  assign bus.count           = count_q;

endmodule
`default_nettype wire
